// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot/periodic reload, pause and compare output
//
// Ports:
//   clock_i                 sole clock, rising edge
//   reset_i                 asynchronous active-high reset, clears all state
//   start_i                 rising edge starts, resumes or reloads
//   stop_i                  rising edge pauses
//   autoreload_i            high: reload at zero instead of expiring (when enabled)
//   preload_value_i         count start value P (0 suppresses the load)
//   compare_value_i         threshold for compare_match_o
//   active_preload_value_o  P latched at the last load/reload
//   value_o                 current count
//   counting_o              high while counting
//   underflow_o             one-cycle pulse per zero event
//   expired_o               high once a one-shot count has finished
//   compare_match_o         counting and value below compare_value_i
module countdown_timer #(
    parameter int bitwidth                = 8,
    parameter int enable_autoreload_input = 0,
    parameter int start_reloads_counting  = 0
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                autoreload_i,
    input  logic [bitwidth-1:0] preload_value_i,
    input  logic [bitwidth-1:0] compare_value_i,
    output logic [bitwidth-1:0] active_preload_value_o,
    output logic [bitwidth-1:0] value_o,
    output logic                counting_o,
    output logic                underflow_o,
    output logic                expired_o,
    output logic                compare_match_o
);
    typedef enum logic [1:0] {IDLE, COUNTING, PAUSED, EXPIRED} state_t;
    localparam logic [bitwidth-1:0] one = 1;
    state_t state_q, state_d;
    logic [bitwidth-1:0] value_q, value_d, active_q, active_d;
    logic underflow_q, underflow_d, start_prev_q, stop_prev_q;
    logic start_edge, stop_edge, load_ok, at_zero, reload_eff, start_reload, load;
    assign start_edge   = start_i & ~start_prev_q;
    assign stop_edge    = stop_i & ~stop_prev_q;
    assign load_ok      = preload_value_i != '0;
    assign at_zero      = value_q == '0;
    assign reload_eff   = (enable_autoreload_input != 0) && autoreload_i && load_ok;
    assign start_reload = (start_reloads_counting != 0) && start_edge && load_ok;
    assign active_d     = load ? preload_value_i : active_q;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            value_q      <= '0;
            active_q     <= '0;
            underflow_q  <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            active_q     <= active_d;
            underflow_q  <= underflow_d;
            start_prev_q <= start_i;
            stop_prev_q  <= stop_i;
        end
    end
    // Any load (reload at zero or start-reload) wins over the hold forced by a stop edge.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        underflow_d = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            IDLE, EXPIRED: if (start_edge && !stop_edge && load_ok) begin
                load    = 1'b1;
                state_d = COUNTING;
            end
            PAUSED: if (start_edge && !stop_edge) begin
                if (start_reloads_counting == 0 && !at_zero) state_d = COUNTING;
                else if (load_ok) begin
                    load    = 1'b1;
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                underflow_d = at_zero;
                load        = (at_zero && reload_eff) || start_reload;
                state_d     = stop_edge ? PAUSED : (at_zero && !load) ? EXPIRED : COUNTING;
                value_d     = (at_zero || stop_edge) ? value_q : value_q - one;
            end
        endcase
        if (load) value_d = preload_value_i;
    end
    always_comb begin
        value_o                = value_q;
        active_preload_value_o = active_q;
        counting_o             = state_q == COUNTING;
        expired_o              = state_q == EXPIRED;
        underflow_o            = underflow_q;
        compare_match_o        = (state_q == COUNTING) && (value_q < compare_value_i);
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer with a spec-level reference model
module tb_countdown_timer;
    logic clock, reset, start, stop, autoreload;
    logic [7:0] preload, compare;
    logic [7:0] val [3];
    logic [7:0] act [3];
    logic [2:0] cnt, uf, ex, cm;
    int errors = 0, checks = 0;
    int ear [3] = '{1, 1, 0};
    int srl [3] = '{0, 1, 0};
    int m_st [3], m_val [3], m_act [3];
    bit m_uf [3];
    bit m_sp, m_tp;

    countdown_timer #(.bitwidth(8), .enable_autoreload_input(1), .start_reloads_counting(0)) dut0 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stop_i(stop), .autoreload_i(autoreload),
        .preload_value_i(preload), .compare_value_i(compare), .active_preload_value_o(act[0]),
        .value_o(val[0]), .counting_o(cnt[0]), .underflow_o(uf[0]), .expired_o(ex[0]), .compare_match_o(cm[0]));
    countdown_timer #(.bitwidth(8), .enable_autoreload_input(1), .start_reloads_counting(1)) dut1 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stop_i(stop), .autoreload_i(autoreload),
        .preload_value_i(preload), .compare_value_i(compare), .active_preload_value_o(act[1]),
        .value_o(val[1]), .counting_o(cnt[1]), .underflow_o(uf[1]), .expired_o(ex[1]), .compare_match_o(cm[1]));
    countdown_timer #(.bitwidth(8), .enable_autoreload_input(0), .start_reloads_counting(0)) dut2 (
        .clock_i(clock), .reset_i(reset), .start_i(start), .stop_i(stop), .autoreload_i(autoreload),
        .preload_value_i(preload), .compare_value_i(compare), .active_preload_value_o(act[2]),
        .value_o(val[2]), .counting_o(cnt[2]), .underflow_o(uf[2]), .expired_o(ex[2]), .compare_match_o(cm[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Model states: 0 idle, 1 counting, 2 paused, 3 expired.
    task automatic model_step(input int i, input bit se, input bit te);
        int p, nv, ns;
        bit ld;
        p = int'(preload);
        m_uf[i] = 1'b0;
        ld = 1'b0;
        if (m_st[i] == 1) begin
            nv = m_val[i] == 0 ? 0 : m_val[i] - 1;
            ns = 1;
            if (m_val[i] == 0) begin
                m_uf[i] = 1'b1;
                if (ear[i] != 0 && autoreload && p != 0) ld = 1'b1;
                else ns = 3;
            end
            if (se && srl[i] != 0 && p != 0) begin
                ld = 1'b1;
                ns = 1;
            end
            if (te) begin
                ns = 2;
                nv = m_val[i];
            end
            if (ld) nv = p;
            m_st[i] = ns;
            m_val[i] = nv;
        end else if (se && !te) begin
            if (m_st[i] == 2 && srl[i] == 0 && m_val[i] != 0) m_st[i] = 1;
            else if (p != 0) begin
                ld = 1'b1;
                m_st[i] = 1;
                m_val[i] = p;
            end
        end
        if (ld) m_act[i] = p;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_st[i] = 0; m_val[i] = 0; m_act[i] = 0; m_uf[i] = 1'b0;
            end
            m_sp = 1'b0;
            m_tp = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) model_step(i, start && !m_sp, stop && !m_tp);
            m_sp = start;
            m_tp = stop;
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d.value", i), int'(val[i]), m_val[i]);
            chk($sformatf("d%0d.active", i), int'(act[i]), m_act[i]);
            chk($sformatf("d%0d.counting", i), int'(cnt[i]), int'(m_st[i] == 1));
            chk($sformatf("d%0d.underflow", i), int'(uf[i]), int'(m_uf[i]));
            chk($sformatf("d%0d.expired", i), int'(ex[i]), int'(m_st[i] == 3));
            chk($sformatf("d%0d.cmp", i), int'(cm[i]), int'(m_st[i] == 1 && m_val[i] < int'(compare)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic lv(input string n, input int i, input int v);
        chk({n, ".dut"}, int'(val[i]), v);
        chk({n, ".model"}, m_val[i], v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; autoreload = 1'b0; preload = 8'd0; compare = 8'd0;
        cyc(2);
        lv("rst.value", 0, 0);
        chk("rst.counting", int'(cnt[0]), 0);
        chk("rst.expired", int'(ex[0]), 0);
        reset = 1'b0;
        cyc(1);
        // one-shot, P=5
        preload = 8'd5;
        pulse_start();
        lv("os.load", 0, 5);
        chk("os.counting", int'(cnt[0]), 1);
        cyc(5);
        lv("os.zero", 0, 0);
        chk("os.uf_early", int'(uf[0]), 0);
        cyc(1);
        chk("os.uf", int'(uf[0]), 1);
        chk("os.expired", int'(ex[0]), 1);
        chk("os.cnt_off", int'(cnt[0]), 0);
        cyc(1);
        chk("os.uf_once", int'(uf[0]), 0);
        lv("os.hold", 0, 0);
        // periodic, P=3 then 6
        do_reset();
        autoreload = 1'b1;
        preload = 8'd3;
        pulse_start();
        cyc(3);
        lv("per.zero", 0, 0);
        cyc(1);
        chk("per.uf1", int'(uf[0]), 1);
        lv("per.reload", 0, 3);
        chk("per.oneshot_exp", int'(ex[2]), 1);
        cyc(1);
        chk("per.uf_width", int'(uf[0]), 0);
        preload = 8'd6;
        cyc(3);
        chk("per.uf2", int'(uf[0]), 1);
        lv("per.reload6", 0, 6);
        chk("per.active6", int'(act[0]), 6);
        cyc(6);
        chk("per.no_uf", int'(uf[0]), 0);
        cyc(1);
        chk("per.uf3", int'(uf[0]), 1);
        // stop edge on a zero event
        cyc(6);
        lv("stz.zero", 0, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stz.uf", int'(uf[0]), 1);
        lv("stz.value", 0, 6);
        chk("stz.paused", int'(cnt[0]), 0);
        // pause / resume, P=10
        do_reset();
        autoreload = 1'b0;
        preload = 8'd10;
        pulse_start();
        cyc(4);
        lv("pr.six", 0, 6);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        lv("pr.stop_hold", 0, 6);
        chk("pr.paused", int'(cnt[0]), 0);
        cyc(20);
        lv("pr.held", 0, 6);
        pulse_start();
        lv("pr.resume", 0, 6);
        lv("pr.reload", 1, 10);
        cyc(1);
        lv("pr.dec0", 0, 5);
        lv("pr.dec1", 1, 9);
        pulse_start();
        lv("pr.nore0", 0, 4);
        lv("pr.rerun1", 1, 10);
        // illegal preload and simultaneous edges
        do_reset();
        preload = 8'd0;
        pulse_start();
        chk("ill.p0", int'(cnt[0]), 0);
        preload = 8'd5;
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("ill.both", int'(cnt[0]), 0);
        lv("ill.value", 0, 0);
        // periodic P=1
        do_reset();
        preload = 8'd1;
        autoreload = 1'b1;
        pulse_start();
        cyc(2);
        chk("p1.uf1", int'(uf[0]), 1);
        cyc(1);
        chk("p1.gap", int'(uf[0]), 0);
        cyc(1);
        chk("p1.uf2", int'(uf[0]), 1);
        autoreload = 1'b0;
        // compare match, P=9, threshold 4
        do_reset();
        preload = 8'd9;
        compare = 8'd4;
        pulse_start();
        chk("cm.9", int'(cm[0]), 0);
        cyc(5);
        chk("cm.4", int'(cm[0]), 0);
        cyc(1);
        chk("cm.3", int'(cm[0]), 1);
        cyc(3);
        chk("cm.0", int'(cm[0]), 1);
        cyc(1);
        chk("cm.expired", int'(cm[0]), 0);
        // asynchronous reset mid-count, P=200
        do_reset();
        preload = 8'd200;
        pulse_start();
        cyc(83);
        lv("ar.117", 0, 117);
        #1 reset = 1'b1;
        #1;
        chk("ar.value", int'(val[0]), 0);
        chk("ar.active", int'(act[0]), 0);
        chk("ar.counting", int'(cnt[0]), 0);
        chk("ar.cm", int'(cm[0]), 0);
        start = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        cyc(1);
        lv("ar.restart", 0, 200);
        chk("ar.cnt", int'(cnt[0]), 1);
        start = 1'b0;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter that pairs with the up-counting `counter` block. It loads a preload value on a start edge and decrements once per clock. It emits a one-cycle `underflow` pulse each time zero has been held for one cycle, then either reloads (periodic mode) or expires (one-shot mode). It also provides a compare output for PWM and timeout generation. It is used for timeouts, periodic ticks and pulse generation elsewhere in the logic-block library.

## Interface
Parameters:
- `bitwidth`, 8: width of `value`, `preload_value`, `compare_value`, `active_preload_value`.
- `enable_autoreload_input`, 0: nonzero → `autoreload` input is evaluated; zero → always one-shot.
- `start_reloads_counting`, 0: nonzero → every start edge reloads, including while counting; zero → start in PAUSED resumes from held value.

Ports:
- `clock` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: rising edge (internally detected) starts, resumes or reloads.
- `stop` in 1: rising edge (internally detected) pauses.
- `autoreload` in 1: high → reload at zero instead of expiring (needs `enable_autoreload_input`).
- `preload_value` in bitwidth: count start value P; P=0 is illegal.
- `compare_value` in bitwidth: threshold for `compare_match`.
- `active_preload_value` out bitwidth: P actually in use, latched at each load/reload.
- `value` out bitwidth: current count.
- `counting` out 1: high in COUNTING.
- `underflow` out 1: one-cycle pulse per zero event.
- `expired` out 1: high in EXPIRED.
- `compare_match` out 1: `counting && (value < compare_value)`, combinational.

## Operation
- Edge detect: registers `start_prev` and `stop_prev` (reset 0). `start_edge = start & ~start_prev`. `stop_edge` is defined the same way. A `start` held high through reset release gives an edge on the first clock.
- States: IDLE (after reset), COUNTING, PAUSED, EXPIRED.
- Load means `value <= preload_value`, `active_preload_value <= preload_value`. A load is suppressed if `preload_value == 0`; the state is then unchanged.
- IDLE / EXPIRED:
  - `start_edge` and no `stop_edge` → load, go to COUNTING.
- PAUSED:
  - `start_edge` and no `stop_edge` → with `start_reloads_counting` = 0 and `value != 0`: resume with value unchanged.
  - Otherwise → load.
  - Either way → COUNTING.
- COUNTING:
  - `value != 0` → `value <= value - 1`.
  - `value == 0` → `underflow <= 1`.
    - Reload effective (`enable_autoreload_input` nonzero, `autoreload` = 1, `preload_value != 0`) → load, stay in COUNTING.
    - Otherwise → go to EXPIRED with `value` held at 0.
  - `start_edge` with `start_reloads_counting` nonzero → load, overriding the decrement. No underflow is issued unless `value == 0` in that same cycle.
  - `stop_edge` → PAUSED, evaluated after the above. It wins over start and over a reload, so `value` keeps any reloaded value. `underflow` is still pulsed if a zero event occurred.
- Simultaneous `start_edge` and `stop_edge` in any non-COUNTING state → no change.
- `underflow` is 0 in every cycle without a zero event.
- Reset (asynchronous, at any time including mid-count):
  - State → IDLE.
  - `value`, `active_preload_value` → 0.
  - `counting`, `underflow`, `expired` → 0.
  - `compare_match` → 0.
  - Edge registers → 0.

## Timing
- Let `start_edge` be sampled at clock edge k with P loaded.
  - Edge k: `counting` = 1, `value` = P.
  - Edge k+i: `value` = P−i.
  - Edge k+P: `value` = 0.
  - Edge k+P+1: `underflow` = 1, then either `value` = P (periodic) or EXPIRED.
- Periodic mode: `underflow` pulses every P+1 cycles, exactly 1 cycle wide. P=1 gives a pulse every 2 cycles.
- `stop_edge` at edge m: `value` at m equals the value at m−1 (no decrement on the stop edge).
- Changing `preload_value` mid-count has no effect until the next load. Only `active_preload_value` reflects the value in use.
- Wrap: `value` never decrements below 0; no arithmetic wrap-around.

## Test plan
- One-shot, P=5: start pulse at edge 10 → `value` 5,4,3,2,1,0 at edges 10..15; `underflow` = 1 only at edge 16; `expired` = 1 and `counting` = 0 from edge 16; `value` stays 0.
- Periodic (`enable_autoreload_input` = 1, `autoreload` = 1), P=3 → `underflow` at edges k+4, k+8, k+12. Set `preload_value` = 6 at k+5 → next reload loads 6 and the following pulse is 7 cycles later.
- Pause/resume, P=10: stop edge when `value` = 6 → PAUSED, `value` holds 6 for 20 cycles. Start edge → continues 6,5,… With `start_reloads_counting` = 1, the same sequence reloads to 10 instead.
- Illegal/simultaneous:
  - `preload_value` = 0 with a start edge → stays IDLE, `counting` = 0.
  - start and stop edges in the same cycle from IDLE → no change.
  - stop edge on a zero-event cycle in periodic mode → `underflow` pulse, `value` = P, state PAUSED.
- Reset mid-count (P=200, `value` = 117), `reset` asserted between clock edges → all outputs 0 immediately, without a clock. With `start` held high across reset release → count restarts at the first clock after release.
- `compare_match`, P=9, `compare_value` = 4 → high exactly while `value` ∈ {3,2,1,0} in COUNTING; low in EXPIRED.
